vslc_timer_bank: RTL and testbench

//  N-channel programmable two-phase timer bank for the VSLC core; generalises the single built-in timer.

---
 rtl/vslc_pkg.sv | 22 ++
 rtl/vslc_timer_channel.sv | 130 +++++++++++++
 rtl/vslc_timer_bank.sv | 48 ++++
 tb/tb_vslc_timer_bank.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vslc_pkg.sv
// Shared constants for the VSLC timer bank:
// mode codes, config-select codes, reset periods.
package vslc_pkg;

  typedef enum logic [1:0] {
    MODE_CYCLE   = 2'd0,
    MODE_ONESHOT = 2'd1,
    MODE_GATED   = 2'd2,
    MODE_RETRIG  = 2'd3
  } mode_e;

  localparam logic [1:0] SEL_PA   = 2'd0;
  localparam logic [1:0] SEL_PB   = 2'd1;
  localparam logic [1:0] SEL_CTRL = 2'd2;

  localparam logic [0:0] PH_A = 1'b0;
  localparam logic [0:0] PH_B = 1'b1;

  localparam int RST_PA = 1;
  localparam int RST_PB = 2;

endpackage

// File: rtl/vslc_timer_channel.sv
// One timer channel: config regs, 2^div prescaler,
// period counter and A/B phase state.
module vslc_timer_channel
  import vslc_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DIV_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_a_i,
  input  logic             wr_b_i,
  input  logic             wr_ctrl_i,
  input  logic [CNT_W-1:0] data_i,
  input  logic             en_set_i,
  input  logic             en_clr_i,
  input  logic             gate_i,
  output logic             out_o,
  output logic             done_o,
  output logic             active_o
);

  localparam int PRE_W = 2**DIV_W - 1;

  logic [CNT_W-1:0] per_a_q, per_a_d;
  logic [CNT_W-1:0] per_b_q, per_b_d;
  logic [DIV_W-1:0] div_q, div_d;
  mode_e            mode_q, mode_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:0]       phase_q, phase_d;
  logic             out_q, out_d;
  logic             done_q, done_d;
  logic             active_q, active_d;

  logic [PRE_W-1:0] pre_lim;
  logic [CNT_W-1:0] per_cur;
  logic             adv, tick, wrap, restart;

  // Prescaler limit is 2^div-1: all bits below div set.
  always_comb begin
    for (int b = 0; b < PRE_W; b++) begin
      pre_lim[b] = (b < int'(div_q));
    end
  end

  always_comb begin
    per_a_d  = wr_a_i ? data_i : per_a_q;
    per_b_d  = wr_b_i ? data_i : per_b_q;
    div_d    = div_q;
    mode_d   = mode_q;
    if (wr_ctrl_i) begin
      div_d  = data_i[DIV_W-1:0];
      mode_d = mode_e'(data_i[DIV_W+1:DIV_W]);
    end

    pre_d    = pre_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    out_d    = out_q;
    done_d   = 1'b0;
    active_d = active_q;

    adv     = active_q &&
              (mode_q != MODE_GATED || gate_i);
    tick    = adv && (pre_q >= pre_lim);
    per_cur = (phase_q == PH_B) ? per_b_q : per_a_q;
    wrap    = tick && (cnt_q >= per_cur);

    if (adv) pre_d = tick ? '0 : pre_q + 1'b1;
    if (tick) cnt_d = wrap ? '0 : cnt_q + 1'b1;

    if (wrap) begin
      phase_d = (phase_q == PH_A) ? PH_B : PH_A;
      out_d   = (phase_q == PH_A);
      if (phase_q == PH_B) begin
        done_d = 1'b1;
        if (mode_q == MODE_ONESHOT ||
            mode_q == MODE_RETRIG) begin
          active_d = 1'b0;
        end
      end
    end

    // A one-shot ending this cycle counts as idle, so
    // a coinciding en_set keeps the channel running.
    restart = en_set_i &&
              (!active_d || mode_q == MODE_RETRIG);

    if (en_clr_i || restart) begin
      pre_d    = '0;
      cnt_d    = '0;
      phase_d  = PH_A;
      out_d    = 1'b0;
      active_d = !en_clr_i;
    end
    if (en_clr_i) done_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      per_a_q  <= CNT_W'(RST_PA);
      per_b_q  <= CNT_W'(RST_PB);
      div_q    <= '0;
      mode_q   <= MODE_CYCLE;
      pre_q    <= '0;
      cnt_q    <= '0;
      phase_q  <= PH_A;
      out_q    <= 1'b0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      per_a_q  <= per_a_d;
      per_b_q  <= per_b_d;
      div_q    <= div_d;
      mode_q   <= mode_d;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      out_q    <= out_d;
      done_q   <= done_d;
      active_q <= active_d;
    end
  end

  assign out_o    = out_q;
  assign done_o   = done_q;
  assign active_o = active_q;

endmodule

// File: rtl/vslc_timer_bank.sv
// N-channel two-phase timer bank: config write
// decode plus one timer channel per output.
module vslc_timer_bank
  import vslc_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int DIV_W = 4,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic [N_CH-1:0]  en_set,
  input  logic [N_CH-1:0]  en_clr,
  input  logic [N_CH-1:0]  gate,
  output logic [N_CH-1:0]  tmr_out,
  output logic [N_CH-1:0]  tmr_done,
  output logic [N_CH-1:0]  tmr_active
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic hit;
    assign hit = cfg_we && (cfg_ch == CH_W'(i));

    vslc_timer_channel #(
      .CNT_W(CNT_W),
      .DIV_W(DIV_W)
    ) u_ch (
      .clk_i    (clk),
      .rst_i    (rst),
      .wr_a_i   (hit && cfg_sel == SEL_PA),
      .wr_b_i   (hit && cfg_sel == SEL_PB),
      .wr_ctrl_i(hit && cfg_sel == SEL_CTRL),
      .data_i   (cfg_data),
      .en_set_i (en_set[i]),
      .en_clr_i (en_clr[i]),
      .gate_i   (gate[i]),
      .out_o    (tmr_out[i]),
      .done_o   (tmr_done[i]),
      .active_o (tmr_active[i])
    );
  end

endmodule

// File: tb/tb_vslc_timer_bank.sv
// Directed bench for vslc_timer_bank: table-driven
// CYCLE run plus hand sequences for the other modes.
module tb_vslc_timer_bank;

  localparam int N  = 3;
  localparam int CW = 16;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [1:0]    cfg_sel;
  logic [CW-1:0] cfg_data;
  logic [N-1:0]  en_set, en_clr, gate;
  logic [N-1:0]  tmr_out, tmr_done, tmr_active;

  int total = 0;
  int bad   = 0;

  vslc_timer_bank #(
    .N_CH (N),
    .CNT_W(CW),
    .DIV_W(DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
    .en_set    (en_set),
    .en_clr    (en_clr),
    .gate      (gate),
    .tmr_out   (tmr_out),
    .tmr_done  (tmr_done),
    .tmr_active(tmr_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic set;
    logic clr;
    logic o;
    logic d;
    logic a;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [3*N-1:0] ev(
    input logic [N-1:0] m,
    input logic o, input logic d, input logic a);
    return {m & {N{o}}, m & {N{d}}, m & {N{a}}};
  endfunction

  task automatic chk(input string nm, input int j,
                     input logic [3*N-1:0] exp);
    logic [3*N-1:0] act;
    act = {tmr_out, tmr_done, tmr_active};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got out/done/act=%b want %b",
               nm, j, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] ch,
                     input logic [1:0] sel,
                     input logic [CW-1:0] d);
    cfg_we = 1'b1; cfg_ch = ch;
    cfg_sel = sel; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0;
    cfg_sel = '0; cfg_data = '0;
    en_set = '0; en_clr = '0; gate = '0;
    tick(); tick();
    chk("reset", 0, '0);
    rst = 1'b0;
    tick();
    chk("post_reset", 0, '0);

    // Test 1: CYCLE with reset config on channel 0
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) begin
      en_set = {2'b00, tbl[i].set};
      en_clr = {2'b00, tbl[i].clr};
      tick();
      chk("cycle", i,
          ev(3'b001, tbl[i].o, tbl[i].d, tbl[i].a));
    end
    en_set = '0; en_clr = '0;

    // Test 2: ONESHOT div=2 PA=0 PB=0 on channel 1
    cfg(2'd1, 2'd2, 16'h0012);
    cfg(2'd1, 2'd0, 16'd0);
    cfg(2'd1, 2'd1, 16'd0);
    en_set = 3'b010;
    tick();
    en_set = '0;
    chk("oneshot", 0, ev(3'b010, 1'b0, 1'b0, 1'b1));
    for (int j = 1; j <= 12; j++) begin
      tick();
      chk("oneshot", j,
          ev(3'b010, (j >= 4 && j < 8), (j == 8), (j < 8)));
    end

    // Test 3: GATED PA=3 PB=3, gate toggling, channel 2
    cfg(2'd2, 2'd2, 16'h0020);
    cfg(2'd2, 2'd0, 16'd3);
    cfg(2'd2, 2'd1, 16'd3);
    en_set = 3'b100;
    tick();
    en_set = '0;
    chk("gated", 0, ev(3'b100, 1'b0, 1'b0, 1'b1));
    for (int j = 1; j <= 24; j++) begin
      gate = {j[0], 2'b00};
      tick();
      chk("gated", j,
          ev(3'b100, ((j >= 7 && j < 15) || j >= 23),
             (j == 15), 1'b1));
    end
    gate = '0;
    en_clr = 3'b100;
    tick();
    en_clr = '0;
    chk("gated_clr", 0, '0);

    // Test 4: RETRIGGER PA=10 PB=10, re-fire mid phase B
    cfg(2'd0, 2'd2, 16'h0030);
    cfg(2'd0, 2'd0, 16'd10);
    cfg(2'd0, 2'd1, 16'd10);
    en_set = 3'b001;
    tick();
    en_set = '0;
    chk("retrig", 0, ev(3'b001, 1'b0, 1'b0, 1'b1));
    for (int j = 1; j <= 42; j++) begin
      en_set = {2'b00, (j == 18)};
      tick();
      chk("retrig", j,
          ev(3'b001,
             ((j >= 11 && j < 18) || (j >= 29 && j < 40)),
             (j == 40), (j < 40)));
    end
    en_set = '0;

    // Test 5: shrink period_a below the live count
    cfg(2'd1, 2'd2, 16'h0000);
    cfg(2'd1, 2'd0, 16'd100);
    cfg(2'd1, 2'd1, 16'd2);
    en_set = 3'b010;
    tick();
    en_set = '0;
    chk("shrink", 0, ev(3'b010, 1'b0, 1'b0, 1'b1));
    for (int j = 1; j <= 52; j++) begin
      cfg_we = (j == 51); cfg_ch = 2'd1;
      cfg_sel = 2'd0; cfg_data = 16'd5;
      tick();
      chk("shrink", j, ev(3'b010, (j == 52), 1'b0, 1'b1));
    end
    cfg_we = 1'b0;
    en_set = 3'b010; en_clr = 3'b010;
    tick();
    en_set = '0; en_clr = '0;
    chk("set_clr", 0, '0);

    // Test 6: ignored writes, then async reset mid phase B
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    cfg(2'd3, 2'd0, 16'd7);
    cfg(2'd0, 2'd3, 16'd5);
    en_set = 3'b111;
    tick();
    en_set = '0;
    chk("ignored", 0, ev(3'b111, 1'b0, 1'b0, 1'b1));
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("ignored", j,
          ev(3'b111, ((j >= 2 && j < 5) || j >= 7),
             (j == 5), 1'b1));
    end
    #2 rst = 1'b1;
    #1 chk("async_rst", 0, '0);
    tick();
    rst = 1'b0;
    chk("async_rst", 1, '0);
    tick();
    chk("async_rst", 2, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
